// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encodings for the UART bus master and its tx handshake.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_PING  = 8'h50;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN,
    ST_WDATA,
    ST_MEM_WR,
    ST_MEM_RD,
    ST_TX,
    ST_DONE
  } bm_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT,
    HS_START,
    HS_DRAIN
  } hs_state_t;

endpackage

// File: rtl/uart_tx_handshake.sv
// Turns a one-cycle send request into the tx_start/tx_busy handshake; pulses done when the byte is out.
module uart_tx_handshake
  import uart_bus_master_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       done
);

  hs_state_t  state_q, state_d;
  logic [1:0] hold_q, hold_d;
  logic       start_d;
  logic [7:0] byte_d;
  logic       done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HS_IDLE;
      hold_q   <= 2'd0;
      tx_start <= 1'b0;
      tx_byte  <= 8'd0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tx_start <= start_d;
      tx_byte  <= byte_d;
      done     <= done_d;
    end
  end

  // hold_q counts tx_start cycles so the request is never shorter than three cycles
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    start_d = tx_start;
    byte_d  = tx_byte;
    done_d  = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (send) begin
          byte_d  = data;
          state_d = HS_WAIT;
        end
      end
      HS_WAIT: begin
        if (!tx_busy) begin
          start_d = 1'b1;
          hold_d  = 2'd0;
          state_d = HS_START;
        end
      end
      HS_START: begin
        if (hold_q != 2'd2) hold_d = hold_q + 2'd1;
        if (tx_busy && hold_q == 2'd2) begin
          start_d = 1'b0;
          state_d = HS_DRAIN;
        end
      end
      HS_DRAIN: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART command parser acting as a memory bus master: ping, block write and block read.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        overrun
);

  localparam int unsigned       GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  bm_state_t        state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [8:0]       count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       hold_q, hold_d;
  logic             pending_q, pending_d;
  logic             rx_prev_q;
  logic [15:0]      addr_d;
  logic [7:0]       wdata_d;
  logic             bus_req_d, overrun_d;
  logic             tx_send_q, tx_send_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_done;
  logic             rx_edge, parse_st, gap_st, take, blocked, timeout;

  uart_tx_handshake u_tx (
    .clk      (clk),
    .reset    (reset),
    .send     (tx_send_q),
    .data     (tx_data_q),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .done     (tx_done)
  );

  // Strobes follow the grant so a withdrawn grant pauses the access without losing it
  assign mem_wr = (state_q == ST_MEM_WR) & bus_gnt;
  assign mem_rd = (state_q == ST_MEM_RD) & bus_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 8'd0;
      count_q   <= 9'd0;
      gap_q     <= '0;
      hold_q    <= 8'd0;
      pending_q <= 1'b0;
      rx_prev_q <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
      bus_req   <= 1'b0;
      overrun   <= 1'b0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      rx_prev_q <= rx_ready;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      bus_req   <= bus_req_d;
      overrun   <= overrun_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    rx_edge   = rx_ready & ~rx_prev_q;
    parse_st  = state_q inside {ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_LEN, ST_WDATA};
    gap_st    = state_q inside {ST_ADDR_H, ST_ADDR_L, ST_LEN, ST_WDATA};
    take      = pending_q & parse_st;
    blocked   = pending_q & ~take;
    timeout   = gap_st & ~take & (gap_q == GAP_LAST);

    state_d   = state_q;
    cmd_d     = cmd_q;
    count_d   = count_q;
    hold_d    = hold_q;
    pending_d = blocked;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    bus_req_d = bus_req;
    overrun_d = overrun;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;

    // A byte consumed this cycle frees the holding register for a simultaneous edge
    if (rx_edge) begin
      if (blocked) begin
        overrun_d = 1'b1;
      end else begin
        hold_d    = rx_byte;
        pending_d = 1'b1;
      end
    end
    gap_d = (gap_st && !(rx_edge && !blocked)) ? gap_q + GAP_W'(1) : '0;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          cmd_d = hold_q;
          if (hold_q == CMD_WRITE || hold_q == CMD_READ) begin
            state_d = ST_ADDR_H;
          end else begin
            tx_data_d = (hold_q == CMD_PING) ? RSP_OK : RSP_ERR;
            state_d   = ST_TX;
          end
        end
      end
      ST_ADDR_H: begin
        if (take) begin
          addr_d  = {hold_q, mem_addr[7:0]};
          state_d = ST_ADDR_L;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_L: begin
        if (take) begin
          addr_d  = {mem_addr[15:8], hold_q};
          state_d = ST_LEN;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (take) begin
          count_d = {hold_q == 8'd0, hold_q};
          state_d = (cmd_q == CMD_WRITE) ? ST_WDATA : ST_MEM_RD;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (take) begin
          wdata_d = hold_q;
          state_d = ST_MEM_WR;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM_WR: begin
        if (mem_ack) begin
          addr_d  = mem_addr + 16'd1;
          count_d = count_q - 9'd1;
          if (count_q == 9'd1) begin
            tx_data_d = RSP_OK;
            state_d   = ST_TX;
          end else begin
            state_d = ST_WDATA;
          end
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          addr_d    = mem_addr + 16'd1;
          count_d   = count_q - 9'd1;
          tx_data_d = mem_rdata;
          state_d   = ST_TX;
        end
      end
      ST_TX: begin
        if (tx_done) begin
          state_d = (cmd_q == CMD_READ && count_q != 9'd0) ? ST_MEM_RD : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus ownership spans the whole command body and drops on completion or abort
    if (state_d inside {ST_MEM_WR, ST_MEM_RD}) begin
      bus_req_d = 1'b1;
    end else if (state_d inside {ST_DONE, ST_IDLE}) begin
      bus_req_d = 1'b0;
    end
    tx_send_d = (state_d == ST_TX) && (state_q != ST_TX);
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed and randomized bench for uart_bus_master with a host/transceiver/memory model.
`timescale 1ns/1ps
module tb_uart_bus_master;

  typedef logic [7:0] bq_t[$];
  localparam int unsigned TO = 150;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        overrun;

  logic        gnt_auto, gnt_man, gnt_r;
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  got[$];
  bit          armed;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          short_starts = 0, tx_unstable = 0, mem_unstable = 0;
  int          breq_cyc = 0, wr_cyc = 0;

  assign bus_gnt = gnt_auto ? gnt_r : gnt_man;

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .overrun   (overrun)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'hFFFF) return 8'h11;
    if (a == 16'h0000) return 8'h22;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory slave: ack one cycle after a strobe is seen; grant wanders only between accesses
  initial begin
    mem_ack = 1'b0; mem_rdata = 8'd0; gnt_r = 1'b1; armed = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_rd || mem_wr) begin
        if (armed) begin
          mem_ack   = 1'b1;
          armed     = 1'b0;
          mem_rdata = mem[mem_addr];
          if (mem_wr) mem[mem_addr] = mem_wdata;
        end else begin
          armed = 1'b1;
        end
      end else begin
        armed = 1'b0;
        gnt_r = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Transceiver transmitter: record the byte on each tx_start rise, then run a busy period
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        got.push_back(tx_byte);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        tx_busy = 1'b1;
        while (tx_start) @(negedge clk);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    int run = 0;
    logic [7:0] last_tx = 8'd0;
    logic strobe_prev = 1'b0;
    logic [15:0] last_addr = 16'd0;
    logic [7:0] last_wd = 8'd0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (run > 0 && tx_byte !== last_tx) tx_unstable++;
        run++;
        last_tx = tx_byte;
      end else begin
        if (run > 0 && run < 3) short_starts++;
        run = 0;
      end
      if ((mem_rd || mem_wr) && strobe_prev && (mem_addr !== last_addr || mem_wdata !== last_wd))
        mem_unstable++;
      strobe_prev = mem_rd || mem_wr;
      last_addr   = mem_addr;
      last_wd     = mem_wdata;
      if (bus_req) breq_cyc++;
      if (mem_wr) wr_cyc++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_byte  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Reference: derive the reply stream and memory effect of one command from the protocol rules
  task automatic run_cmd(input string tag, input int gap, input bq_t b);
    bq_t exp;
    logic [15:0] a, ai;
    int n, base, budget;
    exp = {};
    a = 16'd0;
    n = 0;
    case (b[0])
      8'h50: exp.push_back(8'h4B);
      8'h57, 8'h52: begin
        a = {b[1], b[2]};
        n = (b[3] == 8'd0) ? 256 : int'(b[3]);
        for (int i = 0; i < n; i++) begin
          ai = a + 16'(i);
          if (b[0] == 8'h57) ref_mem[ai] = b[4 + i];
          else exp.push_back(ref_mem[ai]);
        end
        if (b[0] == 8'h57) exp.push_back(8'h4B);
      end
      default: exp.push_back(8'h3F);
    endcase
    base = got.size();
    foreach (b[j]) send_byte(b[j], gap);
    budget = 400 + 80 * exp.size();
    while (got.size() < base + exp.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (40) @(negedge clk);
    chk({tag, "_reply_count"}, 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < got.size()) chk({tag, "_reply_byte"}, {24'd0, got[base + i]}, {24'd0, exp[i]});
    if (b[0] == 8'h57 || b[0] == 8'h52)
      chk({tag, "_end_addr"}, {16'd0, mem_addr}, {16'd0, a + 16'(n)});
    if (b[0] == 8'h57)
      for (int i = 0; i < n; i++) begin
        ai = a + 16'(i);
        chk({tag, "_mem"}, {24'd0, mem[ai]}, {24'd0, ref_mem[ai]});
      end
    chk({tag, "_bus_req_idle"}, {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    bq_t cmd;
    int base, b0, w0, budget;
    logic [7:0] op;
    int len;
    rx_ready = 1'b0; rx_byte = 8'd0; gnt_auto = 1'b1; gnt_man = 1'b0; reset = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    repeat (3) @(negedge clk);
    chk("rst_tx_start",  {31'd0, tx_start},  32'd0);
    chk("rst_tx_byte",   {24'd0, tx_byte},   32'd0);
    chk("rst_bus_req",   {31'd0, bus_req},   32'd0);
    chk("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_strobes",   {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_overrun",   {31'd0, overrun},   32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    b0 = breq_cyc;
    cmd = {8'h50};
    run_cmd("ping", 28, cmd);
    chk("ping_no_bus_req", 32'(breq_cyc - b0), 32'd0);

    cmd = {8'h57, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB};
    run_cmd("write", 28, cmd);

    cmd = {8'h52, 8'hFF, 8'hFF, 8'h02};
    run_cmd("read_wrap", 28, cmd);

    cmd = {8'h41};
    run_cmd("unknown", 28, cmd);
    cmd = {8'h50};
    run_cmd("ping_after_unknown", 28, cmd);

    base = got.size();
    send_byte(8'h57, 28);
    send_byte(8'h00, 28);
    send_byte(8'h10, 28);
    repeat (TO + 40) @(negedge clk);
    chk("timeout_no_reply", 32'(got.size() - base), 32'd0);
    chk("timeout_bus_req",  {31'd0, bus_req}, 32'd0);
    cmd = {8'h50};
    run_cmd("ping_after_timeout", 28, cmd);

    // Gaps just under the abort threshold must not abort
    cmd = {8'h57, 8'h00, 8'h30, 8'h01, 8'h5C};
    run_cmd("slow_write", TO - 20, cmd);

    for (int k = 0; k < 10; k++) begin
      op  = ($urandom_range(0, 2) == 0) ? 8'h57 : 8'h52;
      len = $urandom_range(1, 4);
      cmd = {op, ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom), 8'($urandom), 8'(len)};
      if (op == 8'h57) for (int i = 0; i < len; i++) cmd.push_back(8'($urandom));
      run_cmd("rand_cmd", 28, cmd);
    end
    do op = 8'($urandom); while (op == 8'h50 || op == 8'h57 || op == 8'h52);
    cmd = {op};
    run_cmd("rand_unknown", 28, cmd);
    cmd = {8'h52, 8'($urandom), 8'($urandom), 8'h00};
    run_cmd("read_256", 28, cmd);

    // Grant stall plus overrun: two edges land while the write is waiting for the bus
    chk("pre_overrun", {31'd0, overrun}, 32'd0);
    gnt_man = 1'b0;
    gnt_auto = 1'b0;
    ref_mem[16'h0020] = 8'hA1;
    ref_mem[16'h0021] = 8'hA2;
    base = got.size();
    send_byte(8'h57, 28);
    send_byte(8'h00, 28);
    send_byte(8'h20, 28);
    send_byte(8'h02, 28);
    w0 = wr_cyc;
    send_byte(8'hA1, 28);
    chk("stall_bus_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk); rx_byte = 8'hA2; rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    @(negedge clk); rx_byte = 8'hA3; rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("stall_no_strobe", 32'(wr_cyc - w0), 32'd0);
    gnt_man = 1'b1;
    budget = 600;
    while (got.size() < base + 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (40) @(negedge clk);
    chk("stall_reply_count", 32'(got.size() - base), 32'd1);
    if (got.size() > base) chk("stall_reply", {24'd0, got[base]}, 32'h4B);
    chk("stall_mem0", {24'd0, mem[16'h0020]}, 32'hA1);
    chk("stall_mem1", {24'd0, mem[16'h0021]}, 32'hA2);
    chk("stall_end_addr", {16'd0, mem_addr}, 32'h0022);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    gnt_auto = 1'b1;

    chk("tx_start_min_width", 32'(short_starts), 32'd0);
    chk("tx_byte_stable",     32'(tx_unstable),  32'd0);
    chk("mem_bus_stable",     32'(mem_unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Serial debug/loader engine on the far side of the CPU-visible UART port. It consumes received bytes from a `uart` transceiver, decodes a small binary command protocol, and acts as a bus master that reads or writes system memory (RAM load, memory dump, ping). Responses go back through the same transceiver's transmitter. It sits between the `uart` transceiver and the memory arbiter, in parallel with the CPU.

## Interface
- `TIMEOUT_CYCLES`, default 800000: idle gap between bytes of one command after which the parser aborts (100 ms at 8 MHz).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `rx_byte`  in  8  received byte from transceiver; valid while `rx_ready` is high.
- `rx_ready`  in  1  transceiver level flag; each rising edge is one new byte.
- `tx_busy`  in  1  transceiver transmitter busy.
- `tx_start`  out  1  transmit request; the transceiver acts on its rising edge.
- `tx_byte`  out  8  byte to transmit; stable while `tx_start` is high.
- `bus_req`  out  1  requests memory ownership.
- `bus_gnt`  in  1  arbiter grant.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  8  write data.
- `mem_rd`  out  1  read strobe; held until ack.
- `mem_wr`  out  1  write strobe; held until ack.
- `mem_rdata`  in  8  read data; valid on the ack cycle.
- `mem_ack`  in  1  one-cycle access completion.
- `overrun`  out  1  sticky; a received byte was dropped.

## Operation
- Reset is synchronous and active-high. Every output resets to 0 (`tx_byte`, `mem_addr`, `mem_wdata` = 0). The FSM resets to IDLE, the holding register to empty, and the rx edge detector to 0.
- Rx intake:
  - A registered copy of `rx_ready` is kept; `rx_ready & ~prev` captures `rx_byte` into a one-byte holding register and sets `pending`.
  - The FSM consumes `pending` only in states that parse input.
  - An edge while `pending` is already set drops the new byte and sets `overrun`.
- Commands:
  - `0x50` 'P': ping. Reply `0x4B` 'K'.
  - `0x57` 'W' addr_hi addr_lo len data×N: write N bytes, then reply 'K'.
  - `0x52` 'R' addr_hi addr_lo len: reply with N memory bytes.
  - len 0 means N=256.
  - Any other command byte: reply `0x3F` '?' and return to IDLE.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN, WDATA, MEM_WR, MEM_RD, TX, DONE.
  - IDLE: on a 'W'/'R' byte go to ADDR_H. On 'P' or an unknown byte, load the reply and go to TX.
  - ADDR_H → ADDR_L → LEN.
  - From LEN: 'W' goes to WDATA; 'R' goes to MEM_RD.
  - WDATA: take a byte into `mem_wdata`, go to MEM_WR.
  - MEM_WR / MEM_RD:
    - `bus_req`=1; strobe asserted only while `bus_gnt`=1.
    - On `mem_ack`, drop the strobe, increment `mem_addr` (16-bit wrap, FFFF→0000) and decrement the 9-bit count.
    - MEM_RD then sends `mem_rdata` via TX.
  - After TX, the state depends on the command:
    - 'R' with count≠0: back to MEM_RD.
    - 'W' with count≠0: back to WDATA.
    - 'W' with count=0: load 'K' and go to TX.
    - Otherwise: DONE → IDLE.
- `bus_req` rises on entering the first MEM_* state of a command and falls on entering DONE or on abort.
- Timeout:
  - The gap counter clears on every captured byte and counts only in ADDR_H, ADDR_L, LEN and WDATA.
  - Reaching `TIMEOUT_CYCLES-1` returns the FSM to IDLE with no reply and `bus_req` low.
  - Bytes already written stay written.
- `bus_gnt` dropped mid-access: the strobe deasserts and the access is retried when the grant returns. Address and count are held.

## Timing
- Rx edge to `pending`: 1 cycle. The FSM consumes the byte the following cycle.
- TX handshake, one byte:
  - Wait for `tx_busy`=0 with `tx_start` low.
  - Assert `tx_start` with `tx_byte` and hold it until `tx_busy` is sampled 1.
  - Deassert, then wait for `tx_busy`=0 before leaving TX.
  - `tx_start` is never high for fewer than 3 cycles.
- Memory access: minimum 2 cycles (strobe cycle, ack cycle). The strobe is low the cycle after ack.
- `mem_addr` and `mem_wdata` are stable for the whole strobe.
- Write and ack in the same cycle as a new rx edge: the byte goes to the holding register and no overrun occurs.

## Structure
- Shared package holds:
  - command/reply byte constants: `CMD_PING`, `CMD_WRITE`, `CMD_READ`, `RSP_OK`, `RSP_ERR`;
  - the FSM state encoding.
- One sub-module, `uart_tx_handshake`: it turns a one-cycle `send`+byte into the tx_start/tx_busy handshake and returns `done`.

## Test plan
- Ping: bytes 50 → tx 4B; no `bus_req`.
- Write: 57 12 34 02 AA BB → writes AA@1234 and BB@1235, then tx 4B. `mem_addr` ends at 1236.
- Read with wrap: 52 FF FF 02, with memory FFFF=11 and 0000=22 → tx 11, 22. Address wraps to 0000.
- Unknown command: 41 → tx 3F; the next 50 → tx 4B.
- Timeout: 57 00 10, then no bytes for `TIMEOUT_CYCLES` → FSM in IDLE, no reply; then 50 → 4B.
- Overrun and grant stall:
  - Two rx edges 2 cycles apart while in MEM_WR with `bus_gnt`=0 → `overrun`=1.
  - Strobe held low until grant; one write completes after the grant.
